uart_core_param: RTL and testbench
==================================

Name: uart_core_param

Overview:
- Parametrised full-duplex UART transceiver: one TX serializer and one RX deserializer sharing one clock.
- Configurable in data width, parity mode, stop-bit count and bit period.
- Replaces separate fixed-format tx/rx blocks beneath the UART top; connects to the bus side through valid/ready (TX) and valid-pulse (RX) interfaces.

Parameters:
- CLKS_PER_BIT, 8, clock cycles per serial bit; must be >= 4 and even.
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  DATA_BITS  byte to transmit; sampled on accept.
- tx_valid  in  1  TX request.
- tx_ready  out  1  TX can accept; high only in TX IDLE.
- txd  out  1  serial output; idle high.
- rxd  in  1  serial input; asynchronous to clk.
- rx_data  out  DATA_BITS  last received payload.
- rx_valid  out  1  one-cycle pulse: rx_data and error flags are updated.
- rx_parity_err  out  1  parity mismatch on the last frame (0 when PARITY=0).
- rx_frame_err  out  1  a stop bit was sampled low on the last frame.
- rx_busy  out  1  RX is inside a frame (START through STOP, or WAIT_IDLE).

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: txd=1, tx_ready=1, rx_data=0, rx_valid=0, rx_parity_err=0, rx_frame_err=0, rx_busy=0, both synchronizer flops=1, both FSMs in IDLE, all counters 0.
- TX FSM states: IDLE, START, DATA, PAR, STOP.
  - Accept: tx_valid && tx_ready at a clock edge; tx_data is latched and the FSM enters START.
  - txd=0 from the cycle after accept.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - DATA sends LSB first for DATA_BITS bits.
  - PAR is skipped when PARITY=0. Parity bit: even = XOR of the payload; odd = inverted XOR.
  - STOP holds txd=1 for STOP_BITS*CLKS_PER_BIT cycles, then returns to IDLE with tx_ready=1.
  - Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
  - Back-to-back: with tx_valid held high, the next start bit follows the last stop cycle after exactly one IDLE cycle.
  - tx_data and tx_valid changes while busy are ignored.
- RX synchronizer: rxd passes through 2 flops; rxs denotes the synchronized value.
- RX FSM states: IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
  - IDLE: rxs==0 moves to START with the counter cleared.
  - START: at count CLKS_PER_BIT/2-1 (mid start bit), resample. rxs==1 means a glitch: return to IDLE with no rx_valid and no flag change. Otherwise go to DATA.
  - DATA/PAR/STOP: each bit is sampled once, CLKS_PER_BIT cycles after the previous sample point. DATA shifts in LSB first.
  - PAR: compares the sampled bit against parity computed from the received payload.
  - STOP: samples STOP_BITS bits; any low stop sample sets the frame error.
  - After the last stop sample: the next cycle pulses rx_valid=1 for one cycle, updating rx_data, rx_parity_err and rx_frame_err together. The flags hold until the next rx_valid.
  - Frame error: go to WAIT_IDLE (rx_busy=1) until rxs==1, then IDLE. Otherwise go straight to IDLE.
  - A low rxd beginning immediately after the stop sample point is accepted as a new start bit.
- Latency: rx_valid fires 2 (sync) + (bits-0.5)*CLKS_PER_BIT + 1 cycles after the rxd falling edge, within ±1 cycle.
- Independence: TX and RX are fully independent; simultaneous activity has no interaction.
- Reset mid-frame: asynchronous assertion immediately forces txd=1, tx_ready=1 and both FSMs to IDLE; a partial RX frame is discarded with no rx_valid.
- Counters: each is sized $clog2(CLKS_PER_BIT) bits and wraps only under FSM control, never freely.
- Illegal parameters: stop elaboration with $error.

Test Plan:
- Defaults, txd looped to rxd; send 0xA5 → txd bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles; tx_ready low for 80 cycles; rx_valid once with rx_data=0xA5 and both error flags 0.
- PARITY=2: send 0x07 → parity bit 1; loopback gives rx_data=0x07, rx_parity_err=0. PARITY=1 on the same byte → parity bit 0.
- Bench drives rxd directly with an even-parity frame for 0x03 and a wrong parity bit (1) → rx_valid with rx_data=0x03, rx_parity_err=1.
- rxd low for 3 cycles then high → no rx_valid, rx_busy returns to 0, rx_data unchanged.
- Frame for 0x5A with stop bit forced 0, rxd held low 20 more cycles → rx_valid with rx_frame_err=1; rx_busy stays 1 until rxd rises.
- Reset asserted 30 cycles into a TX of 0xFF → txd=1 and tx_ready=1 in the same cycle; no rx_valid in loopback; the next send of 0x3C is received correctly.

Source files
------------

// File: rtl/uart_core_param.sv
// uart_core_param
//   Full-duplex UART transceiver: one TX serializer and one RX deserializer
//   sharing a single clock. Frame format is fixed at elaboration time:
//   1 start bit, DATA_BITS payload bits (LSB first), optional parity bit,
//   STOP_BITS stop bits, each bit CLKS_PER_BIT clocks long.
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit (>= 4, even)
//   DATA_BITS     payload bits per frame (5..9)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     1 or 2
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   tx_data/valid   transmit payload and request (taken when tx_ready is high)
//   tx_ready        high only while the transmitter is idle
//   txd             serial output, idles high
//   rxd             serial input, asynchronous to clk
//   rx_data         last received payload
//   rx_valid        one-cycle pulse when rx_data and the error flags update
//   rx_parity_err   parity mismatch on the last frame
//   rx_frame_err    a stop bit was sampled low on the last frame
//   rx_busy         receiver is inside a frame or waiting for the line to idle
module uart_core_param #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_clks
    $error("uart_core_param: CLKS_PER_BIT must be >= 4 and even");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_core_param: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_core_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_core_param: STOP_BITS must be 1 or 2");
  end

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;

  tx_state_e              tx_state_q, tx_state_d;
  logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]          tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   tx_par_q, tx_par_d;
  logic                   txd_q, txd_d;
  logic                   tx_ready_q, tx_ready_d;

  // txd is registered: every transition decides the next line level so the
  // output changes exactly on bit boundaries.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    txd_d      = txd_q;
    tx_ready_d = tx_ready_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          tx_state_d = TX_START;
          tx_shift_d = tx_data;
          tx_par_d   = (^tx_data) ^ PAR_ODD;
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
          tx_ready_d = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == DATA_LAST) begin
            tx_bit_d = '0;
            if (PARITY != 0) begin
              tx_state_d = TX_PAR;
              txd_d      = tx_par_q;
            end else begin
              tx_state_d = TX_STOP;
              txd_d      = 1'b1;
            end
          end else begin
            // Shift the next payload bit into position 0.
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_PAR: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_STOP;
          txd_d      = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == STOP_LAST) begin
            tx_bit_d   = '0;
            tx_state_d = TX_IDLE;
            tx_ready_d = 1'b1;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_ready_d = 1'b1;
        txd_d      = 1'b1;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      txd_q      <= txd_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign txd      = txd_q;
  assign tx_ready = tx_ready_q;

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_IDLE} rx_state_e;

  logic                   rx_sync1_q, rx_sync2_q;
  logic                   rxs;
  rx_state_e              rx_state_q, rx_state_d;
  logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]          rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   rx_perr_q, rx_perr_d;   // flags of the frame in flight
  logic                   rx_ferr_q, rx_ferr_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_parity_err_q, rx_parity_err_d;
  logic                   rx_frame_err_q, rx_frame_err_d;
  logic                   rx_busy_q, rx_busy_d;
  logic                   rx_ferr_now;

  assign rxs = rx_sync2_q;

  always_comb begin
    rx_state_d      = rx_state_q;
    rx_cnt_d        = rx_cnt_q;
    rx_bit_d        = rx_bit_q;
    rx_shift_d      = rx_shift_q;
    rx_perr_d       = rx_perr_q;
    rx_ferr_d       = rx_ferr_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = 1'b0;
    rx_parity_err_d = rx_parity_err_q;
    rx_frame_err_d  = rx_frame_err_q;
    rx_ferr_now     = rx_ferr_q | ~rxs;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rxs) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
          rx_perr_d  = 1'b0;
          rx_ferr_d  = 1'b0;
        end
      end
      RX_START: begin
        // Half a bit in: recheck the line so short glitches are dropped and
        // every later sample lands mid-bit.
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rxs ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxs, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DATA_LAST) begin
            rx_bit_d   = '0;
            rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_PAR: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_perr_d  = rxs ^ (^rx_shift_q) ^ PAR_ODD;
          rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d  = '0;
          rx_ferr_d = rx_ferr_now;
          if (rx_bit_q == STOP_LAST) begin
            rx_bit_d        = '0;
            rx_valid_d      = 1'b1;
            rx_data_d       = rx_shift_q;
            rx_parity_err_d = rx_perr_q;
            rx_frame_err_d  = rx_ferr_now;
            // A low stop bit may be a break; wait for the line to return high.
            rx_state_d      = rx_ferr_now ? RX_WAIT_IDLE : RX_IDLE;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_WAIT_IDLE: begin
        if (rxs) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
      end
    endcase
    rx_busy_d = (rx_state_d != RX_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync1_q      <= 1'b1;
      rx_sync2_q      <= 1'b1;
      rx_state_q      <= RX_IDLE;
      rx_cnt_q        <= '0;
      rx_bit_q        <= '0;
      rx_shift_q      <= '0;
      rx_perr_q       <= 1'b0;
      rx_ferr_q       <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      rx_busy_q       <= 1'b0;
    end else begin
      rx_sync1_q      <= rxd;
      rx_sync2_q      <= rx_sync1_q;
      rx_state_q      <= rx_state_d;
      rx_cnt_q        <= rx_cnt_d;
      rx_bit_q        <= rx_bit_d;
      rx_shift_q      <= rx_shift_d;
      rx_perr_q       <= rx_perr_d;
      rx_ferr_q       <= rx_ferr_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      rx_parity_err_q <= rx_parity_err_d;
      rx_frame_err_q  <= rx_frame_err_d;
      rx_busy_q       <= rx_busy_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_parity_err_q;
  assign rx_frame_err  = rx_frame_err_q;
  assign rx_busy       = rx_busy_q;

endmodule

// File: tb/tb_uart_core_param.sv
// Testbench for uart_core_param. Three instances share clk/rst:
//   index 0: defaults (8N1), loopback selectable
//   index 1: PARITY=2 (even), 1 stop, loopback selectable
//   index 2: PARITY=1 (odd), 2 stop bits, always looped back
// A table of transmit vectors is checked bit-by-bit on txd, and every
// rx_valid pulse is checked against a scoreboard queue filled at stimulus time.
module tb_uart_core_param;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data   [3];
  logic       tx_valid  [3];
  logic       tx_ready  [3];
  logic       txd       [3];
  logic       rxd       [3];
  logic       rxd_drv   [3];
  logic       loop_en   [3];
  logic [7:0] rx_data   [3];
  logic       rx_valid  [3];
  logic       rx_perr   [3];
  logic       rx_ferr   [3];
  logic       rx_busy   [3];

  int n_cmp = 0;
  int n_bad = 0;
  int vcount [3];

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       pbit;   // expected parity bit on the line (ignored for sel 0)
    int         len;    // expected frame length in clocks
    bit         keep;   // leave tx_valid high for a back-to-back follow-up
  } vec_t;

  vec_t tbl [10];

  assign rxd[0] = loop_en[0] ? txd[0] : rxd_drv[0];
  assign rxd[1] = loop_en[1] ? txd[1] : rxd_drv[1];
  assign rxd[2] = txd[2];

  uart_core_param u_p0 (
    .clk(clk), .rst(rst),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .txd(txd[0]),
    .rxd(rxd[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .rx_parity_err(rx_perr[0]), .rx_frame_err(rx_ferr[0]), .rx_busy(rx_busy[0])
  );

  uart_core_param #(.PARITY(2)) u_p2 (
    .clk(clk), .rst(rst),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .txd(txd[1]),
    .rxd(rxd[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .rx_parity_err(rx_perr[1]), .rx_frame_err(rx_ferr[1]), .rx_busy(rx_busy[1])
  );

  uart_core_param #(.PARITY(1), .STOP_BITS(2)) u_p1 (
    .clk(clk), .rst(rst),
    .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .txd(txd[2]),
    .rxd(rxd[2]), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]),
    .rx_parity_err(rx_perr[2]), .rx_frame_err(rx_ferr[2]), .rx_busy(rx_busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int s, input exp_t e);
    case (s)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic check_rx(input int s);
    exp_t e;
    bit   have;
    have = 1'b0;
    e    = '0;
    case (s)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    vcount[s]++;
    if (!have) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_unexpected: sel=%0d got rx_valid data=%h, required no rx_valid", s, rx_data[s]);
    end else begin
      $display("rx  sel=%0d data=%h perr=%b ferr=%b (expect %h/%b/%b)",
               s, rx_data[s], rx_perr[s], rx_ferr[s], e.d, e.pe, e.fe);
      chk("rx_frame", 32'({rx_data[s], rx_perr[s], rx_ferr[s]}), 32'(e));
    end
  endtask

  // Advance to the next falling edge and service the receive scoreboards.
  task automatic tick();
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      if (rx_valid[s] === 1'b1) check_rx(s);
    end
  endtask

  task automatic send_frame(input int s, input logic [7:0] d, input logic pbit,
                            input int len, input bit keep);
    logic eb [16];
    int   nb;
    int   bad;
    int   low_cnt;
    exp_t e;
    for (int i = 0; i < 16; i++) eb[i] = 1'b1;
    eb[0] = 1'b0;
    nb = 1;
    for (int i = 0; i < 8; i++) begin
      eb[nb] = d[i];
      nb++;
    end
    if (s != 0) begin
      eb[nb] = pbit;
      nb++;
    end
    for (int k = 0; k < 300 && tx_ready[s] !== 1'b1; k++) tick();
    chk("tx_ready_before_send", 32'(tx_ready[s]), 32'h1);
    tx_data[s]  = d;
    tx_valid[s] = 1'b1;
    e.d = d; e.pe = 1'b0; e.fe = 1'b0;
    push_exp(s, e);
    tick();
    if (!keep) tx_valid[s] = 1'b0;
    tx_data[s] = ~d;   // must be ignored while the frame is in flight
    bad     = 0;
    low_cnt = 0;
    for (int c = 0; c < len; c++) begin
      if (txd[s] !== eb[c / 8]) bad++;
      if (tx_ready[s] === 1'b0) low_cnt++;
      tick();
    end
    $display("tx  sel=%0d data=%h len=%0d bad_cycles=%0d ready_low=%0d", s, d, len, bad, low_cnt);
    chk("txd_bits", 32'(bad), 32'h0);
    chk("tx_ready_low_cycles", 32'(low_cnt), 32'(len));
    chk("tx_idle_after_frame", 32'({tx_ready[s], txd[s]}), 32'h3);
  endtask

  // Drive n bits (bit 0 first) onto rxd of instance s, one bit period each.
  task automatic drive_bits(input int s, input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      rxd_drv[s] = v[i];
      repeat (8) tick();
    end
  endtask

  initial begin
    logic [15:0] fr;
    logic [7:0]  last0;
    int          vbefore;
    bit          saw_busy;
    exp_t        e;

    tbl[0] = '{0, 8'hA5, 1'b0, 80, 1'b0};
    tbl[1] = '{1, 8'h07, 1'b1, 88, 1'b0};
    tbl[2] = '{2, 8'h07, 1'b0, 96, 1'b0};
    tbl[3] = '{0, 8'h11, 1'b0, 80, 1'b1};
    tbl[4] = '{0, 8'h11, 1'b0, 80, 1'b0};
    tbl[5] = '{1, 8'h80, 1'b1, 88, 1'b0};
    tbl[6] = '{2, 8'hFF, 1'b1, 96, 1'b0};
    tbl[7] = '{1, 8'h00, 1'b0, 88, 1'b0};
    tbl[8] = '{2, 8'h5A, 1'b1, 96, 1'b0};
    tbl[9] = '{0, 8'hC3, 1'b0, 80, 1'b0};

    for (int s = 0; s < 3; s++) begin
      tx_data[s]  = 8'h00;
      tx_valid[s] = 1'b0;
      rxd_drv[s]  = 1'b1;
      loop_en[s]  = 1'b1;
      vcount[s]   = 0;
    end
    rst = 1'b1;
    repeat (3) tick();
    for (int s = 0; s < 3; s++) begin
      chk("reset_state",
          32'({txd[s], tx_ready[s], rx_valid[s], rx_data[s], rx_perr[s], rx_ferr[s], rx_busy[s]}),
          32'({1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}));
    end
    rst = 1'b0;
    repeat (4) tick();

    // Table-driven transmit/loopback frames.
    last0 = 8'h00;
    for (int i = 0; i < 10; i++) begin
      send_frame(tbl[i].sel, tbl[i].data, tbl[i].pbit, tbl[i].len, tbl[i].keep);
      if (tbl[i].sel == 0) last0 = tbl[i].data;
      if (!tbl[i].keep) repeat (4) tick();
    end
    repeat (20) tick();

    // Start-bit glitch: 3 low cycles must be rejected.
    loop_en[0] = 1'b0;
    vbefore    = vcount[0];
    saw_busy   = 1'b0;
    rxd_drv[0] = 1'b0;
    repeat (3) tick();
    rxd_drv[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (rx_busy[0] === 1'b1) saw_busy = 1'b1;
      tick();
    end
    $display("glt sel=0 busy_seen=%b busy=%b data=%h", saw_busy, rx_busy[0], rx_data[0]);
    chk("glitch_busy_seen", 32'(saw_busy), 32'h1);
    chk("glitch_busy_clear", 32'(rx_busy[0]), 32'h0);
    chk("glitch_data_hold", 32'(rx_data[0]), 32'(last0));
    chk("glitch_no_valid", 32'(vcount[0]), 32'(vbefore));

    // Even-parity frame for 0x03 carrying a wrong parity bit (1).
    loop_en[1] = 1'b0;
    e.d = 8'h03; e.pe = 1'b1; e.fe = 1'b0;
    push_exp(1, e);
    fr = {5'b0, 1'b1, 1'b1, 8'h03, 1'b0};
    drive_bits(1, fr, 11);
    repeat (10) tick();
    chk("perr_flag_hold", 32'(rx_perr[1]), 32'h1);

    // Frame for 0x5A with a low stop bit, line held low 20 more cycles.
    e.d = 8'h5A; e.pe = 1'b0; e.fe = 1'b1;
    push_exp(0, e);
    fr = {6'b0, 1'b0, 8'h5A, 1'b0};
    drive_bits(0, fr, 10);
    repeat (20) tick();
    $display("brk sel=0 busy=%b ferr=%b", rx_busy[0], rx_ferr[0]);
    chk("ferr_busy_while_low", 32'(rx_busy[0]), 32'h1);
    chk("ferr_flag_hold", 32'(rx_ferr[0]), 32'h1);
    rxd_drv[0] = 1'b1;
    repeat (6) tick();
    chk("ferr_busy_release", 32'(rx_busy[0]), 32'h0);

    // Reset 30 cycles into a loopback transmit of 0xFF.
    loop_en[0] = 1'b1;
    repeat (4) tick();
    vbefore     = vcount[0];
    tx_data[0]  = 8'hFF;
    tx_valid[0] = 1'b1;
    tick();
    tx_valid[0] = 1'b0;
    repeat (29) tick();
    #2 rst = 1'b1;
    #1;
    $display("rst sel=0 txd=%b tx_ready=%b rx_busy=%b", txd[0], tx_ready[0], rx_busy[0]);
    chk("rst_txd_high", 32'(txd[0]), 32'h1);
    chk("rst_tx_ready", 32'(tx_ready[0]), 32'h1);
    chk("rst_rx_busy", 32'(rx_busy[0]), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    repeat (100) tick();
    chk("rst_no_rx_valid", 32'(vcount[0]), 32'(vbefore));
    send_frame(0, 8'h3C, 1'b0, 80, 1'b0);

    // Drain outstanding receive expectations.
    for (int k = 0; k < 300 && (q0.size() + q1.size() + q2.size()) > 0; k++) tick();
    chk("rx_outstanding", 32'(q0.size() + q1.size() + q2.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
